rrs_online_mult: RTL and testbench

RRS_ONLINE_MULT -- requirements
Module: rRs_online_mult

---
 rtl/rrs_pkg.sv | 35 +++
 rtl/rrs_mult_sel.sv | 57 +++++
 rtl/rrs_online_mult.sv | 186 ++++++++++++++++++
 tb/tb_rrs_online_mult.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrs_pkg.sv
// ============================================================================
//  Module   : rrs_pkg
//  Purpose  : Shared digit-width helpers, digit bounds and FSM state codes
//             for the radix-r online multiplier.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rrs_pkg;

   // Bits per signed digit: log2(RADIX) magnitude bits plus a sign bit
   function automatic int digit_width(input int radix);
      return $clog2(radix) + 1;
   endfunction

   // Largest digit of the maximally redundant digit set
   function automatic int digit_max(input int radix);
      return radix - 1;
   endfunction

   // Smallest digit of the maximally redundant digit set
   function automatic int digit_min(input int radix);
      return -(radix - 1);
   endfunction

   // Controller state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/rrs_mult_sel.sv
// ============================================================================
//  Module   : rrs_mult_sel
//  Purpose  : Digit selection and residual update for one online step.
//             V = RADIX*W + T, p = sat(round(V)), W' = V - p.
//             W and T are fixed point with FB fractional bits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rrs_mult_sel
   import rrs_pkg::*;
#(
   parameter int RADIX = 4,
   parameter int WW    = 42,
   parameter int FB    = 22
) (
   input  logic [WW-1:0]                  i_w,
   input  logic [WW-1:0]                  i_t,
   input  logic                           i_sel_en,
   output logic [digit_width(RADIX)-1:0]  o_p,
   output logic [WW-1:0]                  o_w
);

   localparam int c_D = digit_width(RADIX);
   localparam int c_L = c_D - 1;
   localparam logic signed [WW-1:0] c_MAX  = WW'(digit_max(RADIX));
   localparam logic signed [WW-1:0] c_MIN  = WW'(digit_min(RADIX));
   localparam logic [WW-1:0]        c_HALF = WW'(1) << (FB - 1);

   logic [WW-1:0]        w_v;
   logic signed [WW-1:0] w_rnd;
   logic signed [WW-1:0] w_q;

   // Exact round-half-up of V, saturated to the digit set; during the
   // initial (no-output) steps the whole of V stays in the residual.
   always_comb begin
      w_v   = (i_w << c_L) + i_t;
      w_rnd = $signed(w_v + c_HALF) >>> FB;
      if (w_rnd > c_MAX) begin
         w_q = c_MAX;
      end else if (w_rnd < c_MIN) begin
         w_q = c_MIN;
      end else begin
         w_q = w_rnd;
      end
      if (i_sel_en) begin
         o_p = w_q[c_D-1:0];
         o_w = w_v - (w_q << FB);
      end else begin
         o_p = '0;
         o_w = w_v;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rrs_online_mult.sv
// ============================================================================
//  Module   : rrs_online_mult
//  Purpose  : Radix-RADIX online (MSD-first) signed-digit multiplier with
//             online delay DELTA. Accepts WIDTH digit pairs, emits 2*WIDTH
//             product digits. Operands are integers scaled by RADIX^WIDTH,
//             the residual is exact with L*(WIDTH+DELTA) fractional bits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rrs_online_mult
   import rrs_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RADIX = 4,
   parameter int DELTA = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [digit_width(RADIX)-1:0] x_digit,
   input  logic [digit_width(RADIX)-1:0] y_digit,
   output logic                          in_ready,
   output logic [digit_width(RADIX)-1:0] p_digit,
   output logic                          p_valid,
   output logic                          busy,
   output logic                          done
);

   localparam int c_D     = digit_width(RADIX);
   localparam int c_L     = c_D - 1;
   localparam int c_XW    = c_L * WIDTH + 2;
   localparam int c_WW    = c_D * (WIDTH + DELTA + 3);
   localparam int c_FB    = c_L * (WIDTH + DELTA);
   localparam int c_STEPS = 2 * WIDTH + DELTA;
   localparam int c_CW    = $clog2(c_STEPS + 1);
   localparam logic [c_CW-1:0] c_LOAD_LAST  = c_CW'(DELTA - 1);
   localparam logic [c_CW-1:0] c_RUN_LAST   = c_CW'(WIDTH - 1);
   localparam logic [c_CW-1:0] c_FLUSH_LAST = c_CW'(c_STEPS - 1);

   logic [2:0]      r_state;
   logic [c_CW-1:0] r_cnt;
   logic [c_XW-1:0] r_x;
   logic [c_XW-1:0] r_y;
   logic [c_WW-1:0] r_w;
   logic [c_D-1:0]  r_p_digit;
   logic            r_p_valid;

   logic            w_in_phase;
   logic            w_accept;
   logic            w_flush;
   logic            w_step;
   logic            w_sel_en;
   logic [c_D-1:0]  w_xd;
   logic [c_D-1:0]  w_yd;
   int              w_shift;
   logic [c_XW-1:0] w_x_next;
   logic [c_XW-1:0] w_y_next;
   logic [c_WW-1:0] w_x_ext;
   logic [c_WW-1:0] w_yn_ext;
   logic [c_WW-1:0] w_xd_ext;
   logic [c_WW-1:0] w_yd_ext;
   logic [c_WW-1:0] w_t;
   logic [c_WW-1:0] w_w_next;
   logic [c_D-1:0]  w_p;

   assign w_in_phase = (r_state == ST_LOAD) || (r_state == ST_RUN);
   assign w_accept   = w_in_phase && in_valid;
   assign w_flush    = (r_state == ST_FLUSH);
   assign w_step     = w_accept || w_flush;
   assign w_sel_en   = (r_state != ST_LOAD);

   // Flush steps (and stalls) inject zero digits
   assign w_xd = w_accept ? x_digit : '0;
   assign w_yd = w_accept ? y_digit : '0;

   // Digit k (0-based count) carries weight RADIX^-(k+1) in operands scaled by RADIX^WIDTH
   always_comb begin
      w_shift = 0;
      if (int'(r_cnt) < WIDTH) begin
         w_shift = c_L * (WIDTH - 1 - int'(r_cnt));
      end
   end

   assign w_x_next = r_x + ({{(c_XW-c_D){w_xd[c_D-1]}}, w_xd} << w_shift);
   assign w_y_next = r_y + ({{(c_XW-c_D){w_yd[c_D-1]}}, w_yd} << w_shift);

   // T = X_old*y + Y_new*x; the RADIX^-DELTA factor is absorbed by the scaling
   assign w_x_ext  = {{(c_WW-c_XW){r_x[c_XW-1]}}, r_x};
   assign w_yn_ext = {{(c_WW-c_XW){w_y_next[c_XW-1]}}, w_y_next};
   assign w_xd_ext = {{(c_WW-c_D){w_xd[c_D-1]}}, w_xd};
   assign w_yd_ext = {{(c_WW-c_D){w_yd[c_D-1]}}, w_yd};
   assign w_t      = (w_x_ext * w_yd_ext) + (w_yn_ext * w_xd_ext);

   rrs_mult_sel #(
      .RADIX (RADIX),
      .WW    (c_WW),
      .FB    (c_FB)
   ) u_sel (
      .i_w      (r_w),
      .i_t      (w_t),
      .i_sel_en (w_sel_en),
      .o_p      (w_p),
      .o_w      (w_w_next)
   );

   // Controller: sequence LOAD -> RUN -> FLUSH -> DONE, counting steps
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_LOAD;
                  r_cnt   <= '0;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + c_CW'(1);
                  if (r_cnt == c_LOAD_LAST) begin
                     r_state <= (WIDTH == DELTA) ? ST_FLUSH : ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + c_CW'(1);
                  if (r_cnt == c_RUN_LAST) begin
                     r_state <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               r_cnt <= r_cnt + c_CW'(1);
               if (r_cnt == c_FLUSH_LAST) begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Datapath: operand prefixes and residual advance only on a step
   always_ff @(posedge clock) begin
      if (reset) begin
         r_x <= '0;
         r_y <= '0;
         r_w <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_x <= '0;
         r_y <= '0;
         r_w <= '0;
      end else if (w_step) begin
         r_x <= w_x_next;
         r_y <= w_y_next;
         r_w <= w_w_next;
      end
   end

   // Registered product digit; zero whenever not valid
   always_ff @(posedge clock) begin
      if (reset) begin
         r_p_valid <= 1'b0;
         r_p_digit <= '0;
      end else begin
         r_p_valid <= w_step && w_sel_en;
         r_p_digit <= (w_step && w_sel_en) ? w_p : '0;
      end
   end

   assign in_ready = w_in_phase && !reset;
   assign busy     = (r_state != ST_IDLE) && !reset;
   assign done     = (r_state == ST_DONE) && !reset;
   assign p_valid  = r_p_valid && !reset;
   assign p_digit  = reset ? '0 : r_p_digit;

endmodule

`default_nettype wire

// File: tb/tb_rrs_online_mult.sv
// ============================================================================
//  Module   : tb_rrs_online_mult
//  Purpose  : Self-checking bench for rrs_online_mult (RADIX=4, WIDTH=4,
//             DELTA=3). Reference: exact integer product of the operands
//             and the digit-timing rules of the online protocol.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rrs_online_mult;

   localparam int WIDTH = 4;
   localparam int RADIX = 4;
   localparam int DELTA = 3;
   localparam int D     = 3;
   localparam int NOUT  = 2 * WIDTH;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         in_valid;
   logic [D-1:0] x_digit;
   logic [D-1:0] y_digit;
   logic         in_ready;
   logic [D-1:0] p_digit;
   logic         p_valid;
   logic         busy;
   logic         done;

   rrs_online_mult #(
      .WIDTH (WIDTH),
      .RADIX (RADIX),
      .DELTA (DELTA)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .x_digit  (x_digit),
      .y_digit  (y_digit),
      .in_ready (in_ready),
      .p_digit  (p_digit),
      .p_valid  (p_valid),
      .busy     (busy),
      .done     (done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   int got_d[$];
   int got_c[$];
   int done_c[$];
   int ref_d[$];
   int xd[WIDTH];
   int yd[WIDTH];
   int gap[WIDTH];
   int acc_c[WIDTH];
   int s_cyc;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Output monitor, sampled mid-cycle
   always @(negedge clock) begin
      if (p_valid) begin
         got_d.push_back(int'($signed(p_digit)));
         got_c.push_back(cyc);
      end else begin
         check("p_digit_zero_when_invalid", longint'(p_digit), 0);
      end
      if (done) begin
         done_c.push_back(cyc);
         check("done_with_last_digit", longint'(p_valid), 1);
      end
   end

   task automatic check_quiet(input string tag);
      check({tag, "_busy"},     longint'(busy), 0);
      check({tag, "_in_ready"}, longint'(in_ready), 0);
      check({tag, "_p_valid"},  longint'(p_valid), 0);
      check({tag, "_done"},     longint'(done), 0);
      check({tag, "_p_digit"},  longint'(p_digit), 0);
   endtask

   function automatic int rand_digit();
      return int'($urandom_range(2 * RADIX - 2)) - (RADIX - 1);
   endfunction

   // Pulse start, then feed all pairs with the stall pattern in gap[]
   task automatic feed(input int restart_at);
      got_d.delete();
      got_c.delete();
      done_c.delete();
      @(posedge clock); #1;
      start = 1'b1;
      s_cyc = cyc;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         in_valid = 1'b1;
         x_digit  = D'(xd[k]);
         y_digit  = D'(yd[k]);
         start    = (k == restart_at);
         acc_c[k] = cyc;
         check("in_ready_when_feeding", longint'(in_ready), 1);
         @(posedge clock); #1;
         start = 1'b0;
         for (int g = 0; g < gap[k]; g++) begin
            in_valid = 1'b0;
            x_digit  = D'($urandom);
            y_digit  = D'($urandom);
            @(posedge clock); #1;
         end
      end
   endtask

   task automatic run_op(input string tag, input int restart_at);
      longint xi;
      longint yi;
      longint pv;
      int     budget;
      int     exp_c;
      feed(restart_at);
      // garbage with in_valid high while not accepting must be ignored
      in_valid = 1'b1;
      budget   = 0;
      while (done_c.size() == 0 && budget < 60) begin
         x_digit = D'($urandom);
         y_digit = D'($urandom);
         @(posedge clock); #1;
         budget++;
      end
      in_valid = 1'b0;
      check({tag, "_done_seen"}, longint'(done_c.size() > 0), 1);
      xi = 0;
      yi = 0;
      for (int k = 0; k < WIDTH; k++) begin
         xi = xi * RADIX + xd[k];
         yi = yi * RADIX + yd[k];
      end
      pv = 0;
      foreach (got_d[i]) pv = pv * RADIX + got_d[i];
      check({tag, "_count"}, got_d.size(), NOUT);
      check({tag, "_value"}, pv, xi * yi);
      foreach (got_d[i]) begin
         check({tag, "_range"}, longint'(got_d[i] >= -(RADIX - 1) && got_d[i] <= RADIX - 1), 1);
         if (i < WIDTH - DELTA) exp_c = acc_c[DELTA + i] + 1;
         else                   exp_c = acc_c[WIDTH - 1] + 1 + (i + 1 - (WIDTH - DELTA));
         check({tag, "_digit_cycle"}, got_c[i], exp_c);
      end
      if (done_c.size() > 0)
         check({tag, "_done_cycle"}, done_c[0], acc_c[WIDTH - 1] + 1 + WIDTH + DELTA);
   endtask

   task automatic clear_gaps();
      for (int k = 0; k < WIDTH; k++) gap[k] = 0;
   endtask

   task automatic compare_ref(input string tag);
      check({tag, "_len"}, got_d.size(), ref_d.size());
      foreach (ref_d[i])
         check({tag, "_seq"}, (i < got_d.size()) ? got_d[i] : 99, ref_d[i]);
   endtask

   initial begin
      int budget;
      int e1[NOUT];
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      x_digit  = '0;
      y_digit  = '0;
      clear_gaps();

      // Outputs during reset and the cycle after it
      @(posedge clock); #1;
      @(negedge clock);
      check_quiet("in_reset");
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_quiet("after_reset");

      // 0.25 * 0.25 = 0.0625 -> digits 0,1,0,...
      xd = '{1, 0, 0, 0};
      yd = '{1, 0, 0, 0};
      run_op("quarter_sq", -1);
      e1 = '{0, 1, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < NOUT; i++)
         check("quarter_sq_digit", (i < got_d.size()) ? got_d[i] : 99, e1[i]);
      if (done_c.size() > 0)
         check("done_latency_from_start", done_c[0] - s_cyc, 2 * WIDTH + DELTA + 1);

      // Largest operands
      xd = '{3, 3, 3, 3};
      yd = '{3, 3, 3, 3};
      run_op("max_sq", -1);

      // Mixed signs
      xd = '{-3, -3, -3, -3};
      yd = '{1, 2, -1, 0};
      run_op("neg_mixed", -1);

      // Stalls leave the digit sequence unchanged
      xd = '{2, -1, 3, -2};
      yd = '{-3, 1, 0, 2};
      run_op("stall_ref", -1);
      ref_d = got_d;
      gap[1] = 2;
      gap[3] = 3;
      run_op("stall_a", -1);
      compare_ref("stall_a");
      clear_gaps();
      gap[2] = 2;
      run_op("stall_b", -1);
      compare_ref("stall_b");
      clear_gaps();

      // start during RUN is ignored
      xd = '{1, -2, 3, 1};
      yd = '{-1, 3, 2, -3};
      run_op("restart_run", WIDTH - 1);

      // start together with reset is ignored
      @(posedge clock); #1;
      reset = 1'b1;
      start = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      check_quiet("start_with_reset");

      // Reset in the cycle of the 5th output digit
      xd = '{3, -2, 1, 2};
      yd = '{2, 3, -3, 1};
      feed(-1);
      in_valid = 1'b0;
      budget   = 0;
      while (!(p_valid && got_d.size() == 4) && budget < 40) begin
         @(posedge clock); #2;
         budget++;
      end
      check("fifth_digit_reached", longint'(budget < 40), 1);
      reset = 1'b1;
      @(negedge clock);
      check("mid_reset_busy", longint'(busy), 0);
      check("mid_reset_p_valid", longint'(p_valid), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_quiet("after_mid_reset");
      run_op("after_mid_reset_op", -1);

      // Random operands, some with random stalls and a stray start
      for (int t = 0; t < 1000; t++) begin
         for (int k = 0; k < WIDTH; k++) begin
            xd[k]  = rand_digit();
            yd[k]  = rand_digit();
            gap[k] = (t % 4 == 0) ? int'($urandom_range(3)) : 0;
         end
         run_op("random", (t % 7 == 0) ? WIDTH - 1 : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
